// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for mem_responder
//
// Purpose: state encoding, word size and default base address used by
// mem_responder and its backing RAM.
// Ports: none (package).
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned WORD_BYTES        = 4;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

endpackage

// File: rtl/resp_ram.sv
// rtl/resp_ram.sv - word-addressed backing RAM with byte-lane writes
//
// Purpose: DEPTH_WORDS x 32 storage. Writes are synchronous with per-byte
// enables; reads are captured into the response data register, which is
// also cleared on reset and on the response handshake.
// Ports:
//   i_clk, i_rst      clock, synchronous active-low reset (rdata register only)
//   i_wr_en, i_rd_en  one-cycle access strobes from the responder FSM
//   i_clr             clear the response data register
//   i_idx             word index
//   i_wdata, i_wstrb  write data and byte-lane enables
//   o_rdata           registered response data
module resp_ram
  import mem_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic          i_rd_en,
  input  logic          i_clr,
  input  logic [AW-1:0] i_idx,
  input  logic [31:0]   i_wdata,
  input  logic [3:0]    i_wstrb,
  output logic [31:0]   o_rdata
);

  // Contents are deliberately not reset; committed data survives a reset.
  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (i_wstrb[b]) begin
          r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst || i_clr) begin
      r_rdata <= '0;
    end else if (i_rd_en) begin
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-outstanding memory responder with wait states
//
// Purpose: accepts one read/write request, waits LATENCY cycles, performs the
// RAM access once on entry to RESP and holds the response until accepted.
// Ports:
//   i_clk, i_rst                     clock, synchronous active-low reset
//   i_req_valid / o_req_ready        request handshake
//   i_req_wen, i_req_addr            1 = write; byte address
//   i_req_wdata, i_req_wstrb         write data and byte-lane enables
//   o_resp_valid / i_resp_ready      response handshake
//   o_resp_rdata, o_resp_err         read data (0 for writes/faults), fault flag
module mem_responder
  import mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_wen,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_wstrb,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT4 = 4'(LATENCY);
  // 33 bits so that a full 4 GiB span cannot overflow the limit.
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'(WORD_BYTES);

  state_e      r_state;
  logic [3:0]  r_cnt;
  logic        r_req_ready;
  logic        r_wen;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_err;

  state_e      w_next_state;
  logic        w_accept;
  logic        w_enter_resp;
  logic        w_resp_hs;
  logic        w_acc_wen;
  logic [31:0] w_acc_addr;
  logic [31:0] w_acc_wdata;
  logic [3:0]  w_acc_wstrb;
  logic [31:0] w_offset;
  logic        w_fault;
  logic [AW-1:0] w_idx;

  // r_req_ready is only set while in IDLE, so it alone qualifies acceptance.
  assign w_accept  = r_req_ready && i_req_valid;
  assign w_resp_hs = (r_state == ST_RESP) && i_resp_ready;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next_state = (LAT4 == 4'd0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (r_cnt == 4'd1) w_next_state = ST_RESP;
      ST_RESP: if (i_resp_ready) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Gated by reset so a write caught mid-flight is never committed.
  assign w_enter_resp = i_rst && (r_state != ST_RESP) && (w_next_state == ST_RESP);

  // With zero latency the access happens on the accept edge, before the
  // request fields are latched, so take them straight from the inputs.
  always_comb begin
    if (r_state == ST_IDLE) begin
      w_acc_wen   = i_req_wen;
      w_acc_addr  = i_req_addr;
      w_acc_wdata = i_req_wdata;
      w_acc_wstrb = i_req_wstrb;
    end else begin
      w_acc_wen   = r_wen;
      w_acc_addr  = r_addr;
      w_acc_wdata = r_wdata;
      w_acc_wstrb = r_wstrb;
    end
  end

  // Unsigned wrap: addresses below BASE_ADDR become huge offsets and fault.
  assign w_offset = w_acc_addr - BASE_ADDR;
  assign w_fault  = ({1'b0, w_offset} >= SPAN) || (w_acc_addr[1:0] != 2'b00);
  assign w_idx    = w_offset[AW+1:2];

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_req_ready <= 1'b0;
      r_wen       <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_wstrb     <= 4'd0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_req_ready <= (w_next_state == ST_IDLE);
      if (w_accept) begin
        r_wen   <= i_req_wen;
        r_addr  <= i_req_addr;
        r_wdata <= i_req_wdata;
        r_wstrb <= i_req_wstrb;
        r_cnt   <= LAT4;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter_resp) begin
        r_err <= w_fault;
      end else if (w_resp_hs) begin
        r_err <= 1'b0;
      end
    end
  end

  resp_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_wr_en (w_enter_resp && w_acc_wen && !w_fault),
    .i_rd_en (w_enter_resp && !w_acc_wen && !w_fault),
    .i_clr   (w_resp_hs),
    .i_idx   (w_idx),
    .i_wdata (w_acc_wdata),
    .i_wstrb (w_acc_wstrb),
    .o_rdata (o_resp_rdata)
  );

  assign o_req_ready  = r_req_ready;
  assign o_resp_valid = (r_state == ST_RESP);
  assign o_resp_err   = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [2:0]  resp_valid;
  logic [2:0]  resp_ready;
  logic [2:0]  resp_err;
  logic [31:0] resp_rdata [3];
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic [31:0] fault_addr [3];
  int          acc [3];
  int          na;
  logic        seen;
  int          n;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Index 0: LATENCY=0, index 1: LATENCY=1, index 2: LATENCY=2 (default).
  mem_responder #(.LATENCY(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_req_wen(req_wen), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
    .o_resp_valid(resp_valid[0]), .i_resp_ready(resp_ready[0]),
    .o_resp_rdata(resp_rdata[0]), .o_resp_err(resp_err[0])
  );

  mem_responder #(.LATENCY(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_req_wen(req_wen), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
    .o_resp_valid(resp_valid[1]), .i_resp_ready(resp_ready[1]),
    .o_resp_rdata(resp_rdata[1]), .o_resp_err(resp_err[1])
  );

  mem_responder u_dut2 (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid[2]), .o_req_ready(req_ready[2]),
    .i_req_wen(req_wen), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
    .o_resp_valid(resp_valid[2]), .i_resp_ready(resp_ready[2]),
    .o_resp_rdata(resp_rdata[2]), .o_resp_err(resp_err[2])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic ram_set(input int k, input int idx, input logic [31:0] v);
    case (k)
      0:       u_dut0.u_ram.r_mem[idx] = v;
      1:       u_dut1.u_ram.r_mem[idx] = v;
      default: u_dut2.u_ram.r_mem[idx] = v;
    endcase
  endtask

  function automatic logic [31:0] ram_get(input int k, input int idx);
    case (k)
      0:       return u_dut0.u_ram.r_mem[idx];
      1:       return u_dut1.u_ram.r_mem[idx];
      default: return u_dut2.u_ram.r_mem[idx];
    endcase
  endfunction

  task automatic wait_ready(input int k);
    int c;
    c = 0;
    while (!req_ready[k] && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    if (!req_ready[k]) chk("req_ready_timeout", {31'b0, req_ready[k]}, 32'd1);
  endtask

  // Called at posedge+1; lat = edges after the accept edge until resp_valid is seen.
  task automatic do_req(input int k, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        output logic [31:0] rdata, output logic err, output int lt);
    req_wen = wen; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    req_valid[k] = 1'b1;
    wait_ready(k);
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    lt = 0;
    while (!resp_valid[k] && lt < 50) begin
      @(posedge clk); #1;
      lt++;
    end
    if (!resp_valid[k]) chk("resp_valid_timeout", {31'b0, resp_valid[k]}, 32'd1);
    rdata = resp_rdata[k];
    err   = resp_err[k];
    resp_ready[k] = 1'b1;
    @(posedge clk); #1;
    resp_ready[k] = 1'b0;
  endtask

  initial begin
    rst = 1'b0; req_valid = '0; resp_ready = '0;
    req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    fault_addr[0] = 32'h8000_1000;
    fault_addr[1] = 32'h7FFF_FFFC;
    fault_addr[2] = 32'h8000_0002;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {29'b0, req_ready}, 32'd0);
    chk("rst_resp_valid", {29'b0, resp_valid}, 32'd0);
    chk("rst_resp_err", {29'b0, resp_err}, 32'd0);
    chk("rst_rdata", resp_rdata[2], 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("release_req_ready", {29'b0, req_ready}, 32'd7);

    // Latency 2 and 0
    ram_set(2, 0, 32'hDEAD_BEEF);
    do_req(2, 1'b0, 32'h8000_0000, 32'h0, 4'h0, rd, er, lat);
    chk("lat2_cycles", lat, 32'd2);
    chk("lat2_rdata", rd, 32'hDEAD_BEEF);
    chk("lat2_err", {31'b0, er}, 32'd0);
    chk("post_hs_valid", {31'b0, resp_valid[2]}, 32'd0);
    chk("post_hs_rdata", resp_rdata[2], 32'd0);
    chk("post_hs_ready", {31'b0, req_ready[2]}, 32'd1);

    ram_set(0, 0, 32'hDEAD_BEEF);
    do_req(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, rd, er, lat);
    chk("lat0_cycles", lat, 32'd0);
    chk("lat0_rdata", rd, 32'hDEAD_BEEF);

    // Byte-lane writes, including an all-lanes-off write
    ram_set(2, 1, 32'hAAAA_AAAA);
    do_req(2, 1'b1, 32'h8000_0004, 32'h1122_3344, 4'b0101, rd, er, lat);
    chk("wr_rdata_zero", rd, 32'd0);
    chk("wr_err", {31'b0, er}, 32'd0);
    do_req(2, 1'b0, 32'h8000_0004, 32'h0, 4'h0, rd, er, lat);
    chk("bytelane_read", rd, 32'hAA22_AA44);
    do_req(2, 1'b1, 32'h8000_0004, 32'hFFFF_FFFF, 4'b0000, rd, er, lat);
    do_req(2, 1'b0, 32'h8000_0004, 32'h0, 4'h0, rd, er, lat);
    chk("wstrb0_read", rd, 32'hAA22_AA44);

    // Faults: out of range, below base, misaligned; writes must not land
    ram_set(2, 0, 32'h0123_4567);
    ram_set(2, 1023, 32'h89AB_CDEF);
    for (int i = 0; i < 3; i++) begin
      do_req(2, 1'b0, fault_addr[i], 32'h0, 4'h0, rd, er, lat);
      chk("fault_rd_err", {31'b0, er}, 32'd1);
      chk("fault_rd_rdata", rd, 32'd0);
      do_req(2, 1'b1, fault_addr[i], 32'hFFFF_FFFF, 4'hF, rd, er, lat);
      chk("fault_wr_err", {31'b0, er}, 32'd1);
      chk("fault_wr_rdata", rd, 32'd0);
    end
    do_req(2, 1'b0, 32'h8000_0000, 32'h0, 4'h0, rd, er, lat);
    chk("fault_ram0_kept", rd, 32'h0123_4567);
    chk("fault_ram1023_kept", ram_get(2, 1023), 32'h89AB_CDEF);

    // Backpressure on the response
    ram_set(2, 2, 32'hCAFE_F00D);
    req_wen = 1'b0; req_addr = 32'h8000_0008; req_valid[2] = 1'b1;
    wait_ready(2);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    n = 0;
    while (!resp_valid[2] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_rdata", resp_rdata[2], 32'hCAFE_F00D);
      chk("bp_hold", {29'b0, resp_valid[2], req_ready[2], resp_err[2]}, 32'b100);
    end
    resp_ready[2] = 1'b1;
    @(posedge clk); #1;
    resp_ready[2] = 1'b0;
    chk("bp_release", {29'b0, resp_valid[2], req_ready[2], resp_err[2]}, 32'b010);
    chk("bp_release_rdata", resp_rdata[2], 32'd0);

    // Back-to-back with LATENCY=1 and resp_ready tied high
    ram_set(1, 0, 32'h0);
    req_wen = 1'b0; req_addr = 32'h8000_0000;
    resp_ready[1] = 1'b1; req_valid[1] = 1'b1;
    na = 0;
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    for (int i = 0; i < 20 && na < 3; i++) begin
      if (req_ready[1]) begin
        acc[na] = cyc;
        na++;
      end
      @(posedge clk); #1;
    end
    req_valid[1] = 1'b0;
    chk("b2b_count", na, 32'd3);
    chk("b2b_gap1", acc[1] - acc[0], 32'd3);
    chk("b2b_gap2", acc[2] - acc[1], 32'd3);
    repeat (3) @(posedge clk);
    #1;
    resp_ready[1] = 1'b0;

    // Reset while a write sits in WAIT with the counter at 1
    ram_set(2, 3, 32'h0);
    req_wen = 1'b1; req_addr = 32'h8000_000C; req_wdata = 32'h5555_5555; req_wstrb = 4'hF;
    req_valid[2] = 1'b1;
    wait_ready(2);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (resp_valid[2]) seen = 1'b1;
    end
    chk("rst_mid_no_resp", {31'b0, seen}, 32'd0);
    chk("rst_mid_ram3", ram_get(2, 3), 32'd0);
    do_req(2, 1'b0, 32'h8000_000C, 32'h0, 4'h0, rd, er, lat);
    chk("rst_mid_readback", rd, 32'd0);
    do_req(2, 1'b0, 32'h8000_0004, 32'h0, 4'h0, rd, er, lat);
    chk("rst_keeps_committed", rd, 32'hAA22_AA44);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
